bcd_stopwatch_counter: RTL and testbench

Four-digit BCD stopwatch counter that produces the `count0`..`count3` digits consumed by the LCD driver stage directly downstream. It conditions two raw push-buttons (start/stop, clear), runs a start/pause/clear state machine, and prescales `clk_1ms` into count ticks. It feeds the driver with always-valid decimal digits.

---
 rtl/bcd_stopwatch_counter_pkg.sv | 18 +
 rtl/bcd_stopwatch_counter_button_debounce.sv | 50 +++++
 rtl/bcd_stopwatch_counter.sv | 107 ++++++++++
 tb/tb_bcd_stopwatch_counter.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/bcd_stopwatch_counter_pkg.sv
// Shared definitions for the BCD stopwatch: digit geometry and the
// start/pause/clear state encoding.
package bcd_stopwatch_counter_pkg;

    localparam int DIGIT_W   = 4;
    localparam int NUM_DIGITS = 4;

    typedef logic [DIGIT_W-1:0] digit_t;

    localparam digit_t DIGIT_MAX = 4'd9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

endpackage

// File: rtl/bcd_stopwatch_counter_button_debounce.sv
// Raw push-button conditioner: two-flop synchronizer, stability counter
// and a registered one-cycle pulse on each accepted press.
module button_debounce #(
    parameter int DEBOUNCE_MS = 20
) (
    input  logic clk_1ms,
    input  logic reset,
    input  logic btn,
    output logic press
);

    localparam int CNT_W = $clog2(DEBOUNCE_MS + 1);

    logic             sync0;
    logic             sync1;
    logic             stable;
    logic             stable_d;
    logic [CNT_W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge value of its neighbours (the synchronizer
    // chain would collapse to one flop with blocking assignments).
    always_ff @(posedge clk_1ms or posedge reset) begin
        if (reset) begin
            sync0    <= 1'b0;
            sync1    <= 1'b0;
            stable   <= 1'b0;
            stable_d <= 1'b0;
            cnt      <= '0;
            press    <= 1'b0;
        end else begin
            sync0    <= btn;
            sync1    <= sync0;
            stable_d <= stable;
            press    <= stable & ~stable_d;

            // Any cycle where the input agrees with the accepted level
            // restarts the count, so short bounces never get through.
            if (sync1 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEBOUNCE_MS - 1)) begin
                stable <= sync1;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/bcd_stopwatch_counter.sv
// Four-digit BCD stopwatch: debounced start/clear buttons, IDLE/RUN/PAUSE
// control, millisecond prescaler and a ripple-free BCD digit chain.
module bcd_stopwatch_counter
    import bcd_stopwatch_counter_pkg::*;
#(
    parameter int TICK_MS     = 10,
    parameter int DEBOUNCE_MS = 20
) (
    input  logic               clk_1ms,
    input  logic               reset,
    input  logic               btn_start,
    input  logic               btn_clear,
    output logic [DIGIT_W-1:0] count0,
    output logic [DIGIT_W-1:0] count1,
    output logic [DIGIT_W-1:0] count2,
    output logic [DIGIT_W-1:0] count3,
    output logic               running,
    output logic               overflow
);

    localparam int PRESC_W = (TICK_MS > 1) ? $clog2(TICK_MS) : 1;

    logic               start_press;
    logic               clear_press;
    state_t             state;
    state_t             next_state;
    logic [PRESC_W-1:0] presc;
    logic               tick;
    digit_t             digits [NUM_DIGITS];
    logic               carry  [NUM_DIGITS+1];

    button_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_start_btn (
        .clk_1ms (clk_1ms),
        .reset   (reset),
        .btn     (btn_start),
        .press   (start_press)
    );

    button_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_clear_btn (
        .clk_1ms (clk_1ms),
        .reset   (reset),
        .btn     (btn_clear),
        .press   (clear_press)
    );

    // NOTE: next_state is defaulted before the case so every path assigns
    // it and no latch is inferred.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (start_press && !clear_press) next_state = RUN;
            RUN:     if (clear_press)      next_state = IDLE;
                     else if (start_press) next_state = PAUSE;
            PAUSE:   if (clear_press)      next_state = IDLE;
                     else if (start_press) next_state = RUN;
            default: next_state = IDLE;
        endcase
    end

    assign tick = (state == RUN) && (presc == PRESC_W'(TICK_MS - 1));

    // carry[i] enables digit i; carry[NUM_DIGITS] marks the 9999 wrap.
    always_comb begin
        carry[0] = tick;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            carry[i+1] = carry[i] && (digits[i] == DIGIT_MAX);
        end
    end

    always_ff @(posedge clk_1ms or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            running  <= 1'b0;
            overflow <= 1'b0;
            presc    <= '0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                digits[i] <= '0;
            end
        end else begin
            state    <= next_state;
            running  <= (next_state == RUN);
            overflow <= carry[NUM_DIGITS] && (next_state != IDLE);

            if (next_state == IDLE) begin
                presc <= '0;
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    digits[i] <= '0;
                end
            end else if (state == RUN) begin
                // The edge leaving RUN still advances, so PAUSE holds the
                // prescaler value reached on that edge.
                presc <= tick ? '0 : presc + PRESC_W'(1);
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (carry[i]) begin
                        digits[i] <= (digits[i] == DIGIT_MAX) ? '0 : digits[i] + digit_t'(1);
                    end
                end
            end
        end
    end

    assign count0 = digits[0];
    assign count1 = digits[1];
    assign count2 = digits[2];
    assign count3 = digits[3];

endmodule

// File: tb/tb_bcd_stopwatch_counter.sv
// Directed bench: instance A (TICK_MS=10, DEBOUNCE_MS=20) for button,
// pause and reset behaviour; instance B (TICK_MS=1) for the 9999 wrap.
module tb_bcd_stopwatch_counter;

    logic       clk_1ms = 1'b0;
    logic       reset;
    logic       a_btn_start, a_btn_clear;
    logic       b_btn_start, b_btn_clear;
    logic [3:0] a_count0, a_count1, a_count2, a_count3;
    logic [3:0] b_count0, b_count1, b_count2, b_count3;
    logic       a_running, a_overflow, b_running, b_overflow;
    logic [15:0] a_digits, b_digits;

    int asserts_n = 0;
    int failures_n = 0;
    int ovf_seen = 0;

    assign a_digits = {a_count3, a_count2, a_count1, a_count0};
    assign b_digits = {b_count3, b_count2, b_count1, b_count0};

    always #5 clk_1ms = ~clk_1ms;

    bcd_stopwatch_counter #(.TICK_MS(10), .DEBOUNCE_MS(20)) dut_a (
        .clk_1ms   (clk_1ms),
        .reset     (reset),
        .btn_start (a_btn_start),
        .btn_clear (a_btn_clear),
        .count0    (a_count0),
        .count1    (a_count1),
        .count2    (a_count2),
        .count3    (a_count3),
        .running   (a_running),
        .overflow  (a_overflow)
    );

    bcd_stopwatch_counter #(.TICK_MS(1), .DEBOUNCE_MS(2)) dut_b (
        .clk_1ms   (clk_1ms),
        .reset     (reset),
        .btn_start (b_btn_start),
        .btn_clear (b_btn_clear),
        .count0    (b_count0),
        .count1    (b_count1),
        .count2    (b_count2),
        .count3    (b_count3),
        .running   (b_running),
        .overflow  (b_overflow)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        asserts_n++;
        assert (observed === expected)
        else begin
            failures_n++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk_1ms);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        a_btn_start = 1'b0; a_btn_clear = 1'b0;
        b_btn_start = 1'b0; b_btn_clear = 1'b0;
        step(3);
        reset = 1'b0;
        step(2);
        check("reset_digits", 32'(a_digits), 32'h0000);
        check("reset_running", 32'(a_running), 32'd0);
        check("reset_overflow", 32'(a_overflow), 32'd0);

        // Bounce: toggle every 5 cycles for 100 cycles, never accepted.
        for (int i = 0; i < 20; i++) begin
            a_btn_start = ~a_btn_start;
            step(5);
        end
        a_btn_start = 1'b0;
        step(30);
        check("bounce_running", 32'(a_running), 32'd0);
        check("bounce_digits", 32'(a_digits), 32'h0000);

        // Clean start press: capture at edge k, RUN at k+23.
        a_btn_start = 1'b1;
        step(1);
        step(22);
        check("start_k22_running", 32'(a_running), 32'd0);
        step(1);
        check("start_k23_running", 32'(a_running), 32'd1);
        step(9);
        check("first_tick_early", 32'(a_count0), 32'd0);
        step(1);
        check("first_tick", 32'(a_count0), 32'd1);
        a_btn_start = 1'b0;
        step(990);
        check("hundred_ticks", 32'(a_digits), 32'h0100);
        check("hundred_running", 32'(a_running), 32'd1);
        step(230);
        check("pre_reset_digits", 32'(a_digits), 32'h0123);

        // Asynchronous reset mid-run, observed before the next edge.
        reset = 1'b1;
        #1;
        check("async_reset_digits", 32'(a_digits), 32'h0000);
        check("async_reset_running", 32'(a_running), 32'd0);
        step(2);
        reset = 1'b0;
        step(5);
        check("post_reset_running", 32'(a_running), 32'd0);
        check("post_reset_digits", 32'(a_digits), 32'h0000);

        // Run again (RUN entered at E), pause at E+74: digits 7, prescaler 4.
        a_btn_start = 1'b1;
        step(1);
        step(23);
        check("rerun_running", 32'(a_running), 32'd1);
        a_btn_start = 1'b0;
        step(50);
        a_btn_start = 1'b1;
        step(1);
        step(22);
        check("prepause_digits", 32'(a_digits), 32'h0007);
        check("prepause_running", 32'(a_running), 32'd1);
        step(1);
        check("pause_running", 32'(a_running), 32'd0);
        a_btn_start = 1'b0;
        step(50);
        check("pause_hold_digits", 32'(a_digits), 32'h0007);
        check("pause_hold_running", 32'(a_running), 32'd0);

        // Resume at R: prescaler continues from 4, so count0=8 at R+6.
        a_btn_start = 1'b1;
        step(1);
        step(23);
        check("resume_running", 32'(a_running), 32'd1);
        step(5);
        check("resume_r5", 32'(a_count0), 32'd7);
        step(1);
        check("resume_r6", 32'(a_count0), 32'd8);
        a_btn_start = 1'b0;
        step(30);

        // Start and clear pressed together in RUN: clear wins.
        a_btn_start = 1'b1;
        a_btn_clear = 1'b1;
        step(1);
        step(22);
        check("both_k22_running", 32'(a_running), 32'd1);
        step(1);
        check("both_running", 32'(a_running), 32'd0);
        check("both_digits", 32'(a_digits), 32'h0000);
        a_btn_start = 1'b0;
        a_btn_clear = 1'b0;
        step(30);

        // Clear alone in IDLE changes nothing.
        a_btn_clear = 1'b1;
        step(30);
        a_btn_clear = 1'b0;
        step(30);
        check("idle_clear_running", 32'(a_running), 32'd0);
        check("idle_clear_digits", 32'(a_digits), 32'h0000);

        // Instance B: one tick per cycle, RUN at k+5, wrap at E+10000.
        b_btn_start = 1'b1;
        step(1);
        step(4);
        check("b_k4_running", 32'(b_running), 32'd0);
        step(1);
        check("b_k5_running", 32'(b_running), 32'd1);
        b_btn_start = 1'b0;
        for (int n = 1; n <= 10001; n++) begin
            step(1);
            ovf_seen += int'(b_overflow);
            if (n == 9999) begin
                check("b_9999_digits", 32'(b_digits), 32'h9999);
                check("b_9999_overflow", 32'(b_overflow), 32'd0);
            end else if (n == 10000) begin
                check("b_wrap_digits", 32'(b_digits), 32'h0000);
                check("b_wrap_overflow", 32'(b_overflow), 32'd1);
            end else if (n == 10001) begin
                check("b_after_digits", 32'(b_digits), 32'h0001);
                check("b_after_overflow", 32'(b_overflow), 32'd0);
            end
        end
        check("b_overflow_pulses", 32'(ovf_seen), 32'd1);
        check("b_still_running", 32'(b_running), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", asserts_n, failures_n);
        $finish;
    end

endmodule
